// File: rtl/usb_host_pkg.sv
// Shared definitions for the full-speed USB host transmitter and its CRC helper.
package usb_host_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_DATA, S_CRC_LO, S_CRC_HI, S_EOP_SE0, S_EOP_J
  } state_t;

  // Line states packed as {D+, D-}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam logic [7:0]  SYNC_BYTE  = 8'h80;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam int          MAX_ONES   = 6;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    for (int i = 0; i < 8; i++) rev8[i] = b[7-i];
  endfunction
endpackage

// File: rtl/usb_crc16.sv
// Serial CRC16 (poly 0x8005), one bit per enabled cycle; shared with the receive-side checker.
module usb_crc16
  import usb_host_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        bit_valid,
  input  logic        bit_in,
  output logic [15:0] crc
);
  logic [15:0] r_crc;

  always_ff @(posedge clk) begin
    if (!reset_n || clear)
      r_crc <= CRC16_INIT;
    else if (bit_valid)
      r_crc <= {r_crc[14:0], 1'b0} ^ ((r_crc[15] ^ bit_in) ? CRC16_POLY : 16'h0000);
  end

  assign crc = r_crc;
endmodule

// File: rtl/usb_host_tx.sv
// Full-speed USB host packet transmitter: SYNC, NRZI + bit-stuffed payload, optional CRC16, EOP.
module usb_host_tx
  import usb_host_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic       clk_48mhz,
  input  logic       reset_n,
  input  logic       pkt_start,
  input  logic       pkt_crc16,
  input  logic [7:0] data,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  output logic       busy,
  output logic       underrun,
  output logic       usb_tx_en,
  output logic       usb_p_tx,
  output logic       usb_n_tx
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int EW = (EOP_SE0_BITS > 1) ? $clog2(EOP_SE0_BITS) : 1;

  state_t          r_state, w_state;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [7:0]      r_shift, w_shift;
  logic [2:0]      r_bits, w_bits;
  logic [2:0]      r_ones, w_ones;
  logic [EW-1:0]   r_eop, w_eop;
  logic [1:0]      r_line, w_line;
  logic            r_lvl, w_lvl;
  logic            r_tx_en, w_tx_en;
  logic            r_busy, w_busy;
  logic            r_crc_en, w_crc_en;
  logic            r_last, w_last;
  logic            r_pid, w_pid;
  logic            r_underrun, w_underrun;

  logic            w_bit_end, w_send, w_stuff, w_bit, w_load, w_eop_go;
  logic            w_data_ready, w_crc_clr, w_crc_vld;
  logic [7:0]      w_byte;
  logic [15:0]     w_crc;

  assign w_bit_end = (r_cnt == CW'(CLKS_PER_BIT - 1));

  usb_crc16 u_crc (
    .clk       (clk_48mhz),
    .reset_n   (reset_n),
    .clear     (w_crc_clr),
    .bit_valid (w_crc_vld),
    .bit_in    (w_bit),
    .crc       (w_crc)
  );

  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_bits     <= '0;
      r_ones     <= '0;
      r_eop      <= '0;
      r_line     <= LINE_J;
      r_lvl      <= 1'b1;
      r_tx_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_crc_en   <= 1'b0;
      r_last     <= 1'b0;
      r_pid      <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_shift    <= w_shift;
      r_bits     <= w_bits;
      r_ones     <= w_ones;
      r_eop      <= w_eop;
      r_line     <= w_line;
      r_lvl      <= w_lvl;
      r_tx_en    <= w_tx_en;
      r_busy     <= w_busy;
      r_crc_en   <= w_crc_en;
      r_last     <= w_last;
      r_pid      <= w_pid;
      r_underrun <= w_underrun;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_cnt        = w_bit_end ? '0 : r_cnt + 1'b1;
    w_shift      = r_shift;
    w_bits       = r_bits;
    w_ones       = r_ones;
    w_eop        = r_eop;
    w_line       = r_line;
    w_lvl        = r_lvl;
    w_tx_en      = r_tx_en;
    w_busy       = r_busy;
    w_crc_en     = r_crc_en;
    w_last       = r_last;
    w_pid        = r_pid;
    w_underrun   = 1'b0;
    w_data_ready = 1'b0;
    w_crc_clr    = 1'b0;
    w_send       = 1'b0;
    w_stuff      = 1'b0;
    w_bit        = 1'b0;
    w_load       = 1'b0;
    w_byte       = '0;
    w_eop_go     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        if (pkt_start) begin
          w_state   = S_SYNC;
          w_busy    = 1'b1;
          w_tx_en   = 1'b1;
          w_crc_en  = pkt_crc16;
          w_crc_clr = 1'b1;
          w_load    = 1'b1;
          w_byte    = SYNC_BYTE;
        end
      end
      S_SYNC, S_DATA, S_CRC_LO, S_CRC_HI: if (w_bit_end) begin
        // A pending stuff bit always wins, so it precedes the next byte or EOP.
        if (r_ones == 3'(MAX_ONES)) begin
          w_send  = 1'b1;
          w_stuff = 1'b1;
        end else if (r_bits != '0) begin
          w_send  = 1'b1;
          w_bit   = r_shift[0];
          w_shift = {1'b0, r_shift[7:1]};
          w_bits  = r_bits - 1'b1;
        end else if (r_state == S_CRC_LO) begin
          w_state = S_CRC_HI;
          w_load  = 1'b1;
          w_byte  = rev8(~w_crc[7:0]);
        end else if (r_state == S_CRC_HI || (r_state == S_DATA && r_last && !r_crc_en)) begin
          w_eop_go = 1'b1;
        end else if (r_state == S_DATA && r_last) begin
          // CRC register MSB goes on the wire first, hence the bit reversal.
          w_state = S_CRC_LO;
          w_load  = 1'b1;
          w_byte  = rev8(~w_crc[15:8]);
        end else begin
          w_data_ready = 1'b1;
          if (data_valid) begin
            w_state = S_DATA;
            w_load  = 1'b1;
            w_byte  = data;
            w_last  = data_last;
            w_pid   = (r_state == S_SYNC);
          end else begin
            w_underrun = 1'b1;
            w_eop_go   = 1'b1;
          end
        end
      end
      S_EOP_SE0: if (w_bit_end) begin
        if (r_eop == EW'(EOP_SE0_BITS - 1)) begin
          w_state = S_EOP_J;
          w_line  = LINE_J;
        end else begin
          w_eop = r_eop + 1'b1;
        end
      end
      S_EOP_J: if (w_bit_end) begin
        w_state = S_IDLE;
        w_tx_en = 1'b0;
        w_busy  = 1'b0;
        w_lvl   = 1'b1;
        w_line  = LINE_J;
      end
      default: w_state = S_IDLE;
    endcase

    if (w_load) begin
      w_send  = 1'b1;
      w_bit   = w_byte[0];
      w_shift = {1'b0, w_byte[7:1]};
      w_bits  = 3'd7;
    end
    if (w_send) begin
      w_lvl  = w_bit ? r_lvl : ~r_lvl;
      w_ones = w_bit ? r_ones + 1'b1 : '0;
      w_line = w_lvl ? LINE_J : LINE_K;
    end
    if (w_eop_go) begin
      w_state = S_EOP_SE0;
      w_eop   = '0;
      w_line  = LINE_SE0;
    end
    w_crc_vld = w_send && !w_stuff && (w_state == S_DATA) && !w_pid;
  end

  assign data_ready = w_data_ready;
  assign busy       = r_busy;
  assign underrun   = r_underrun;
  assign usb_tx_en  = r_tx_en;
  assign usb_p_tx   = r_line[1];
  assign usb_n_tx   = r_line[0];
endmodule

// File: tb/tb_usb_host_tx.sv
// Scoreboard bench for usb_host_tx: a list-based packet model predicts the per-cycle line trace.
`timescale 1ns/1ps
module tb_usb_host_tx;
  localparam int CPB = 4;
  localparam int SE0B = 2;

  logic       clk_48mhz = 1'b0;
  logic       reset_n = 1'b0;
  logic       pkt_start = 1'b0, pkt_crc16 = 1'b0;
  logic [7:0] data = 8'h00;
  logic       data_valid = 1'b0, data_last = 1'b0;
  logic       data_ready, busy, underrun, usb_tx_en, usb_p_tx, usb_n_tx;

  int tests = 0, fails = 0;

  usb_host_tx #(.CLKS_PER_BIT(CPB), .EOP_SE0_BITS(SE0B)) dut (
    .clk_48mhz(clk_48mhz), .reset_n(reset_n), .pkt_start(pkt_start), .pkt_crc16(pkt_crc16),
    .data(data), .data_valid(data_valid), .data_last(data_last), .data_ready(data_ready),
    .busy(busy), .underrun(underrun), .usb_tx_en(usb_tx_en), .usb_p_tx(usb_p_tx), .usb_n_tx(usb_n_tx)
  );

  always #10 clk_48mhz = ~clk_48mhz;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  function automatic void chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endfunction

  function automatic logic [15:0] crc_step(input logic [15:0] c, input bit b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h8005 : 16'h0000);
  endfunction

  // Expected packets: per-packet length plus a flat stream of per-cycle {p,n} levels.
  int         exp_len[$];
  logic [1:0] exp_lines[$];
  int         exp_und[$];
  bit         exp_res[$];

  function automatic void push_exp(input logic [7:0] b[$], input bit crc, input int und);
    bit bits[$];
    bit st[$];
    logic [7:0]  s;
    logic [15:0] c;
    int n, ones;
    logic lvl;
    s = 8'h80;
    n = (und >= 0) ? und : b.size();
    for (int j = 0; j < 8; j++) bits.push_back(s[j]);
    c = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 8; j++) begin
        bits.push_back(b[i][j]);
        if (i > 0) c = crc_step(c, b[i][j]);
      end
    if (crc && und < 0)
      for (int j = 15; j >= 0; j--) bits.push_back(~c[j]);
    ones = 0;
    foreach (bits[k]) begin
      st.push_back(bits[k]);
      ones = bits[k] ? ones + 1 : 0;
      if (ones == 6) begin st.push_back(1'b0); ones = 0; end
    end
    lvl = 1'b1;
    foreach (st[k]) begin
      if (!st[k]) lvl = ~lvl;
      repeat (CPB) exp_lines.push_back({lvl, ~lvl});
    end
    repeat (SE0B * CPB) exp_lines.push_back(2'b00);
    repeat (CPB) exp_lines.push_back(2'b10);
    exp_len.push_back(CPB * (st.size() + SE0B + 1));
    exp_und.push_back((und >= 0) ? 1 : 0);
    exp_res.push_back(crc && und < 0);
  endfunction

  // Monitor: capture each tx_en window and score it against the next expected packet.
  logic [1:0] mon_cap[$];
  int  mon_und = 0;
  bit  mon_in = 0;
  bit  mon_discard = 0;
  int  last_len = 0;

  function automatic void finish_pkt();
    int len, mism, und, ones, nb;
    bit res, b;
    logic [1:0] e, prev;
    logic [15:0] c;
    if (mon_discard) begin mon_discard = 0; return; end
    chk("pkt_expected", int'(exp_len.size() != 0), 1);
    if (exp_len.size() == 0) return;
    len = exp_len.pop_front();
    und = exp_und.pop_front();
    res = exp_res.pop_front();
    last_len = mon_cap.size();
    chk("pkt_len", mon_cap.size(), len);
    mism = -1;
    for (int i = 0; i < len; i++) begin
      e = exp_lines.pop_front();
      if (mism < 0 && (i >= mon_cap.size() || mon_cap[i] !== e)) mism = i;
    end
    chk("line_first_bad_cycle", mism, -1);
    chk("busy_low_at_end", int'(busy), 0);
    chk("underrun_pulses", mon_und, und);
    if (res) begin
      prev = 2'b10; ones = 0; nb = 0; c = 16'hFFFF;
      for (int i = 0; i + CPB <= mon_cap.size(); i += CPB) begin
        if (mon_cap[i] == 2'b00) break;
        b = (mon_cap[i] == prev);
        prev = mon_cap[i];
        if (ones == 6) begin ones = 0; continue; end
        ones = b ? ones + 1 : 0;
        if (nb >= 16) c = crc_step(c, b);
        nb++;
      end
      chk("crc_residual", int'(c), 32'h800D);
    end
  endfunction

  initial begin
    forever begin
      @(negedge clk_48mhz);
      if (usb_tx_en === 1'b1) begin
        mon_cap.push_back({usb_p_tx, usb_n_tx});
        if (underrun) mon_und++;
        mon_in = 1;
      end else if (mon_in) begin
        mon_in = 0;
        finish_pkt();
        mon_cap.delete();
        mon_und = 0;
      end
    end
  end

  task automatic send_pkt(input logic [7:0] b[$], input bit crc, input int und);
    int idx, g;
    bit hs;
    push_exp(b, crc, und);
    g = 0;
    while (busy && g < 2000) begin @(negedge clk_48mhz); g++; end
    pkt_start = 1; pkt_crc16 = crc; idx = 0;
    data = b[0]; data_last = (b.size() == 1); data_valid = (und != 0);
    @(negedge clk_48mhz);
    pkt_start = 0; pkt_crc16 = 0;
    g = 0;
    while (busy && g < 5000) begin
      hs = data_ready && data_valid;
      @(negedge clk_48mhz); g++;
      if (hs) begin
        idx++;
        if (idx < b.size()) begin
          data = b[idx]; data_last = (idx == b.size() - 1); data_valid = (idx != und);
        end else begin
          data_valid = 0; data_last = 0;
        end
      end
    end
    chk("pkt_done_in_time", int'(busy), 0);
    data_valid = 0; data_last = 0;
    @(negedge clk_48mhz);
  endtask

  logic [7:0] q[$];

  initial begin
    int rises, gap, g, n, und;
    bit prev, crc;
    repeat (2) @(negedge clk_48mhz);
    chk("reset_outputs", int'({usb_tx_en, usb_p_tx, usb_n_tx, busy, data_ready, underrun}), 6'b010000);
    reset_n = 1;
    @(negedge clk_48mhz);

    // ACK handshake
    q.delete(); q.push_back(8'hD2);
    send_pkt(q, 0, -1);
    chk("ack_len", last_len, 76);

    // One stuff bit inside 0xFF
    q.delete(); q.push_back(8'hC3); q.push_back(8'hFF);
    send_pkt(q, 0, -1);
    chk("stuff_len", last_len, 112);

    // CRC over empty payload
    q.delete(); q.push_back(8'h4B);
    send_pkt(q, 1, -1);
    chk("crc_empty_len", last_len, 140);

    // Underrun after the PID
    q.delete(); q.push_back(8'hC3); q.push_back(8'h11);
    send_pkt(q, 1, 1);

    // Reset during DATA
    mon_discard = 1;
    pkt_start = 1; pkt_crc16 = 0; data = 8'hC3; data_valid = 1; data_last = 0;
    @(negedge clk_48mhz);
    pkt_start = 0;
    repeat (50) @(negedge clk_48mhz);
    reset_n = 0;
    @(negedge clk_48mhz);
    chk("midreset_outputs", int'({usb_tx_en, usb_p_tx, usb_n_tx, busy, underrun}), 5'b01000);
    reset_n = 1; data_valid = 0;
    @(negedge clk_48mhz);
    q.delete(); q.push_back(8'h5A);
    send_pkt(q, 0, -1);

    // Back-to-back with pkt_start held high
    q.delete(); q.push_back(8'hD2);
    push_exp(q, 0, -1); push_exp(q, 0, -1);
    pkt_start = 1; pkt_crc16 = 0; data = 8'hD2; data_valid = 1; data_last = 1;
    rises = 0; gap = 0; prev = 0; g = 0;
    while (rises < 2 && g < 1000) begin
      @(negedge clk_48mhz); g++;
      if (usb_tx_en && !prev) rises++;
      if (rises == 1 && !usb_tx_en) gap++;
      prev = usb_tx_en;
    end
    pkt_start = 0;
    chk("b2b_second_start", rises, 2);
    chk("b2b_gap_cycles", gap, 1);
    repeat (20) @(negedge clk_48mhz);
    pkt_start = 1;
    @(negedge clk_48mhz);
    pkt_start = 0;
    g = 0;
    while (busy && g < 1000) begin @(negedge clk_48mhz); g++; end
    chk("b2b_done", int'(busy), 0);
    data_valid = 0; data_last = 0;
    repeat (10) @(negedge clk_48mhz);

    // Randomized packets, biased toward 0xFF to exercise stuffing
    for (int t = 0; t < 14; t++) begin
      n = $urandom_range(1, 5);
      q.delete();
      for (int i = 0; i < n; i++)
        q.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      crc = 1'($urandom_range(0, 1));
      und = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      send_pkt(q, crc, und);
    end

    repeat (20) @(negedge clk_48mhz);
    chk("all_pkts_seen", exp_len.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
